// File: rtl/wb_arbiter_rr_if.sv
// Bundle of the N-master request side and the single external Wishbone bus
// around wb_arbiter_rr; "slave" is the arbiter's view, "master" the environment's.
interface wb_arbiter_rr_if #(
  parameter int N_MST = 2,
  parameter int DW    = 16,
  parameter int AW    = 24,
  parameter int SW    = 2
);
  localparam int SELW = (N_MST > 1) ? $clog2(N_MST) : 1;

  logic [N_MST-1:0]    i_wb_cyc;
  logic [N_MST-1:0]    i_wb_stb;
  logic [N_MST-1:0]    i_wb_we;
  logic [N_MST-1:0]    i_wb_4_burst;
  logic [N_MST-1:0]    i_wb_8_burst;
  logic [N_MST*AW-1:0] i_wb_adr;
  logic [N_MST*SW-1:0] i_wb_sel;
  logic [N_MST*DW-1:0] i_wb_o_dat;
  logic [N_MST-1:0]    o_wb_ack;
  logic [N_MST-1:0]    o_wb_err;

  logic                owb_cyc;
  logic                owb_stb;
  logic                owb_we;
  logic                owb_4_burst;
  logic                owb_8_burst;
  logic [AW-1:0]       owb_adr;
  logic [SW-1:0]       owb_sel;
  logic [DW-1:0]       owb_o_dat;
  logic                owb_ack;
  logic                owb_err;

  logic [SELW-1:0]     o_sel_sig;
  logic                o_grant_valid;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_4_burst, i_wb_8_burst,
    input  i_wb_adr, i_wb_sel, i_wb_o_dat,
    output o_wb_ack, o_wb_err,
    output owb_cyc, owb_stb, owb_we, owb_4_burst, owb_8_burst,
    output owb_adr, owb_sel, owb_o_dat,
    input  owb_ack, owb_err,
    output o_sel_sig, o_grant_valid
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_4_burst, i_wb_8_burst,
    output i_wb_adr, i_wb_sel, i_wb_o_dat,
    input  o_wb_ack, o_wb_err,
    input  owb_cyc, owb_stb, owb_we, owb_4_burst, owb_8_burst,
    input  owb_adr, owb_sel, owb_o_dat,
    output owb_ack, owb_err,
    input  o_sel_sig, o_grant_valid
  );
endinterface

// File: rtl/wb_arbiter_rr.sv
// N-master Wishbone round-robin arbiter; owner keeps the bus for its whole cyc.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr #(
  parameter int N_MST       = 2,
  parameter int DW          = 16,
  parameter int AW          = 24,
  parameter int SW          = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  wb_arbiter_rr_if.slave bus
);
  localparam int SELW = (N_MST > 1) ? $clog2(N_MST) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0] win;
  logic [SELW-1:0] sel_inc;
  logic            cyc_g;
  logic            to_hit;

  // First requester at or after rr_ptr, wrapping with an explicit compare
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_MST; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_MST) idx = idx - N_MST;
      if (!found && bus.i_wb_cyc[idx]) begin
        found = 1'b1;
        win   = SELW'(idx);
      end
    end
  end

  assign cyc_g   = bus.i_wb_cyc[sel_q];
  assign sel_inc = (sel_q == SELW'(N_MST-1)) ? '0 : sel_q + 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    to_hit = 1'b0;
    if (state_q == GRANT && cyc_g && bus.i_wb_stb[sel_q] && !bus.owb_ack && !bus.owb_err) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(TIMEOUT_CYC)) to_hit = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |8'(TIMEOUT_CYC);
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.i_wb_cyc) begin
          state_d = GRANT;
          sel_d   = win;
        end
      end
      GRANT: begin
        if (!cyc_g || to_hit) begin
          state_d  = IDLE;
          rr_ptr_d = sel_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.owb_cyc     = 1'b0;
    bus.owb_stb     = 1'b0;
    bus.owb_we      = 1'b0;
    bus.owb_4_burst = 1'b0;
    bus.owb_8_burst = 1'b0;
    bus.owb_adr     = '0;
    bus.owb_sel     = '0;
    bus.owb_o_dat   = '0;
    bus.o_wb_ack    = '0;
    bus.o_wb_err    = '0;
    if (state_q == GRANT) begin
      bus.owb_cyc     = cyc_g;
      bus.owb_stb     = bus.i_wb_stb[sel_q];
      bus.owb_we      = bus.i_wb_we[sel_q];
      bus.owb_4_burst = bus.i_wb_4_burst[sel_q];
      bus.owb_8_burst = bus.i_wb_8_burst[sel_q];
      bus.owb_adr     = bus.i_wb_adr[int'(sel_q)*AW +: AW];
      bus.owb_sel     = bus.i_wb_sel[int'(sel_q)*SW +: SW];
      bus.owb_o_dat   = bus.i_wb_o_dat[int'(sel_q)*DW +: DW];
      bus.o_wb_ack[sel_q] = bus.owb_ack;
      bus.o_wb_err[sel_q] = bus.owb_err;
      // Watchdog abort: strobe the error to the owner and pull the bus away
      if (to_hit) begin
        bus.owb_cyc         = 1'b0;
        bus.owb_stb         = 1'b0;
        bus.o_wb_err[sel_q] = 1'b1;
      end
    end
  end

  assign bus.o_sel_sig     = sel_q;
  assign bus.o_grant_valid = (state_q == GRANT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule
